// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store initiator for a registered, word-wide data memory.
// Accepts one request at a time, issues byte-strobed word accesses (two when the
// access crosses a word boundary) and returns sign/zero-extended load data.
//
// Handshake: a request transfers on a cycle where REQ_VALID && REQ_READY are both high
// at the rising edge; REQ_READY is high only in IDLE, so requests never overlap.
// The response is a single-cycle RSP_VALID pulse carrying RSP_RDATA and RSP_ERR.
module load_store_unit #(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        MEM_EN,
  output logic        MEM_WE,
  output logic [3:0]  MEM_WSTRB,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA,
  output logic [2:0]  DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACC0 = 3'd1,
    S_ACC1 = 3'd2,
    S_WAIT = 3'd3,
    S_RESP = 3'd4
  } state_t;

  // Access size in bytes from funct3[1:0]; 11 only occurs for illegal requests.
  function automatic logic [2:0] f_size(input logic [1:0] f);
    case (f)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] f_mask(input logic [1:0] f);
    case (f)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // An access crosses into the next word when offset + size exceeds 4 bytes.
  function automatic logic f_split(input logic [1:0] off, input logic [1:0] f);
    return (({1'b0, off} + f_size(f)) > 3'd4);
  endfunction

  function automatic logic f_illegal(input logic we, input logic [2:0] f);
    if (we) return (f[2] || (f == 3'b011));
    else    return ((f == 3'b011) || (f == 3'b110) || (f == 3'b111));
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_lo;
  logic [31:0] r_hi;

  logic        w_req_err;
  logic [1:0]  w_off;
  logic        w_split;
  logic [7:0]  w_smask;
  logic [63:0] w_sdata;
  logic [31:0] w_word_addr;
  logic [31:0] w_next_addr;
  logic [31:0] w_ld_word;
  logic [31:0] w_ld_data;

  assign w_req_err   = f_illegal(REQ_WE, REQ_FUNCT3) ||
                       (!MISALIGN_EN && f_split(REQ_ADDR[1:0], REQ_FUNCT3[1:0]));
  assign w_off       = r_addr[1:0];
  assign w_split     = f_split(w_off, r_funct3[1:0]);
  assign w_smask     = {4'b0000, f_mask(r_funct3[1:0])} << w_off;
  assign w_sdata     = {32'd0, r_wdata} << {w_off, 3'b000};
  assign w_word_addr = {r_addr[31:2], 2'b00};
  assign w_next_addr = w_word_addr + 32'd4;
  assign w_ld_word   = 32'({r_hi, r_lo} >> {w_off, 3'b000});
  assign DBG_STATE   = r_state;

  // Load result: select bytes by size, extend by funct3[2] (1 = unsigned).
  always_comb begin
    w_ld_data = w_ld_word;
    case (r_funct3[1:0])
      2'b00:   w_ld_data = {{24{w_ld_word[7] & ~r_funct3[2]}}, w_ld_word[7:0]};
      2'b01:   w_ld_data = {{16{w_ld_word[15] & ~r_funct3[2]}}, w_ld_word[15:0]};
      default: w_ld_data = w_ld_word;
    endcase
  end

  // Next-state and output decode; every output defaults to its idle value.
  always_comb begin
    w_next    = r_state;
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    RSP_ERR   = 1'b0;
    RSP_RDATA = 32'd0;
    MEM_EN    = 1'b0;
    MEM_WE    = 1'b0;
    MEM_WSTRB = 4'd0;
    MEM_ADDR  = 32'd0;
    MEM_WDATA = 32'd0;
    case (r_state)
      S_IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) w_next = w_req_err ? S_RESP : S_ACC0;
      end
      S_ACC0: begin
        MEM_EN   = 1'b1;
        MEM_ADDR = w_word_addr;
        if (r_we) begin
          MEM_WE    = 1'b1;
          MEM_WSTRB = w_smask[3:0];
          MEM_WDATA = w_sdata[31:0];
        end
        if (w_split)   w_next = S_ACC1;
        else if (r_we) w_next = S_RESP;
        else           w_next = S_WAIT;
      end
      S_ACC1: begin
        MEM_EN   = 1'b1;
        MEM_ADDR = w_next_addr;
        if (r_we) begin
          MEM_WE    = 1'b1;
          MEM_WSTRB = w_smask[7:4];
          MEM_WDATA = w_sdata[63:32];
        end
        w_next = r_we ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        RSP_VALID = 1'b1;
        RSP_ERR   = r_err;
        RSP_RDATA = (r_we || r_err) ? 32'd0 : w_ld_data;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register, request capture and read-word capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_err    <= 1'b0;
      r_lo     <= 32'd0;
      r_hi     <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && REQ_VALID) begin
        r_we     <= REQ_WE;
        r_funct3 <= REQ_FUNCT3;
        r_addr   <= REQ_ADDR;
        r_wdata  <= REQ_WDATA;
        r_err    <= w_req_err;
      end
      // In ACC1 the memory is returning the ACC0 word (lower address).
      if (r_state == S_ACC1 && !r_we) r_lo <= MEM_RDATA;
      // In WAIT the last-read word arrives: upper word if split, else the only word.
      if (r_state == S_WAIT) begin
        if (w_split) r_hi <= MEM_RDATA;
        else         r_lo <= MEM_RDATA;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed registered memory model, reference byte
// memory updated at request time, response scoreboard with expected data/err/cycle.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  dbg_state;

  logic        nm_req_valid, nm_req_ready, nm_rsp_valid, nm_rsp_err;
  logic [31:0] nm_req_addr, nm_rsp_rdata;
  logic        nm_mem_en, nm_mem_we;
  logic [3:0]  nm_mem_wstrb;
  logic [31:0] nm_mem_addr, nm_mem_wdata;
  logic [31:0] nm_mem_rdata = 32'h12345678;
  logic [2:0]  nm_dbg_state;

  int chk_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int nm_en_cnt = 0;

  logic [7:0]  mem     [0:63];
  logic [7:0]  ref_mem [0:63];
  logic [32:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] acc_addr_q[$];
  logic [31:0] acc_data_q[$];
  logic [3:0]  acc_strb_q[$];
  logic        acc_we_q[$];

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit #(.MISALIGN_EN(1'b1)) u_dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_WE(req_we), .REQ_FUNCT3(req_funct3), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_WSTRB(mem_wstrb), .MEM_ADDR(mem_addr),
    .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata), .DBG_STATE(dbg_state)
  );

  load_store_unit #(.MISALIGN_EN(1'b0)) u_dut_nm (
    .CLK(clk), .RST(rst), .REQ_VALID(nm_req_valid), .REQ_READY(nm_req_ready),
    .REQ_WE(1'b0), .REQ_FUNCT3(3'b010), .REQ_ADDR(nm_req_addr), .REQ_WDATA(32'd0),
    .RSP_VALID(nm_rsp_valid), .RSP_RDATA(nm_rsp_rdata), .RSP_ERR(nm_rsp_err),
    .MEM_EN(nm_mem_en), .MEM_WE(nm_mem_we), .MEM_WSTRB(nm_mem_wstrb), .MEM_ADDR(nm_mem_addr),
    .MEM_WDATA(nm_mem_wdata), .MEM_RDATA(nm_mem_rdata), .DBG_STATE(nm_dbg_state)
  );

  // Registered 64-byte memory model (address bits above [5:0] ignored)
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[{mem_addr[5:2], b[1:0]}] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= {mem[{mem_addr[5:2], 2'd3}], mem[{mem_addr[5:2], 2'd2}],
                      mem[{mem_addr[5:2], 2'd1}], mem[{mem_addr[5:2], 2'd0}]};
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: scoreboard pop on responses, log memory accesses
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexp_rsp", 64'd1, 64'd0);
      end else begin
        logic [32:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("rsp_data", 64'(rsp_rdata), 64'(e[31:0]));
        check("rsp_err", 64'(rsp_err), 64'(e[32]));
        check("rsp_lat", 64'(cyc), 64'(ec));
      end
    end
    if (mem_en === 1'b1) begin
      acc_addr_q.push_back(mem_addr);
      acc_data_q.push_back(mem_wdata);
      acc_strb_q.push_back(mem_wstrb);
      acc_we_q.push_back(mem_we);
    end
    if (nm_mem_en === 1'b1) nm_en_cnt++;
  end

  function automatic int ref_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    v = 32'd0;
    n = ref_size(f3);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[6'(a + 32'(i))];
    if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = ref_size(f3);
    for (int i = 0; i < n; i++) ref_mem[6'(a + 32'(i))] = wd[8*i +: 8];
  endtask

  task automatic clear_acc();
    acc_addr_q.delete();
    acc_data_q.delete();
    acc_strb_q.delete();
    acc_we_q.delete();
  endtask

  // Driver: issue one request, push expectation, wait for the scoreboard to drain
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    logic ill, spl;
    logic [31:0] d;
    int lat, k;
    @(negedge clk);
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (req_ready !== 1'b1) begin
      check("ready_timeout", 64'(req_ready), 64'd1);
      return;
    end
    ill = we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    spl = (int'(a[1:0]) + ref_size(f3)) > 4;
    d   = 32'd0;
    if (ill)     lat = 1;
    else if (we) lat = spl ? 3 : 2;
    else         lat = spl ? 4 : 3;
    if (!ill && we)  ref_store(f3, a, wd);
    if (!ill && !we) d = ref_load(f3, a);
    exp_q.push_back({ill, d});
    exp_cyc_q.push_back(cyc + lat);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      check("rsp_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic chk_acc(input string tag, input int idx, input logic we, input logic [3:0] strb,
                         input logic [31:0] a, input logic [31:0] wd);
    if (acc_addr_q.size() <= idx) begin
      check({tag, "_missing"}, 64'(acc_addr_q.size()), 64'(idx + 1));
      return;
    end
    check({tag, "_we"}, 64'(acc_we_q[idx]), 64'(we));
    check({tag, "_strb"}, 64'(acc_strb_q[idx]), 64'(strb));
    check({tag, "_addr"}, 64'(acc_addr_q[idx]), 64'(a));
    if (we) check({tag, "_wdata"}, 64'(acc_data_q[idx]), 64'(wd));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int k, t;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 8'd0;
      ref_mem[i] = 8'd0;
    end
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    nm_req_valid = 1'b0; nm_req_addr = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_wstrb", 64'(mem_wstrb), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b0;

    clear_acc();
    do_req(1'b1, 3'b010, 32'h0, 32'hAABBCCDD);
    check("sw0_cnt", 64'(acc_addr_q.size()), 64'd1);
    chk_acc("sw0", 0, 1'b1, 4'b1111, 32'h0, 32'hAABBCCDD);
    clear_acc();
    do_req(1'b0, 3'b010, 32'h0, 32'h0);
    check("lw0_cnt", 64'(acc_addr_q.size()), 64'd1);
    chk_acc("lw0", 0, 1'b0, 4'b0000, 32'h0, 32'h0);

    clear_acc();
    do_req(1'b1, 3'b000, 32'h1, 32'h000000FF);
    chk_acc("sb1", 0, 1'b1, 4'b0010, 32'h0, 32'h0000FF00);
    do_req(1'b0, 3'b000, 32'h1, 32'h0);
    do_req(1'b0, 3'b100, 32'h1, 32'h0);

    clear_acc();
    do_req(1'b1, 3'b010, 32'h6, 32'h11223344);
    check("sw6_cnt", 64'(acc_addr_q.size()), 64'd2);
    chk_acc("sw6_a0", 0, 1'b1, 4'b1100, 32'h4, 32'h33440000);
    chk_acc("sw6_a1", 1, 1'b1, 4'b0011, 32'h8, 32'h00001122);
    do_req(1'b0, 3'b010, 32'h6, 32'h0);

    do_req(1'b1, 3'b000, 32'h7, 32'h00000080);
    do_req(1'b1, 3'b000, 32'h8, 32'h00000000);
    clear_acc();
    do_req(1'b0, 3'b001, 32'h7, 32'h0);
    check("lh7_cnt", 64'(acc_addr_q.size()), 64'd2);
    do_req(1'b0, 3'b101, 32'h2, 32'h0);
    do_req(1'b0, 3'b001, 32'h2, 32'h0);

    clear_acc();
    do_req(1'b1, 3'b010, 32'hFFFFFFFE, 32'hCAFEF00D);
    chk_acc("wrap_a0", 0, 1'b1, 4'b1100, 32'hFFFFFFFC, 32'hF00D0000);
    chk_acc("wrap_a1", 1, 1'b1, 4'b0011, 32'h00000000, 32'h0000CAFE);
    do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);

    clear_acc();
    do_req(1'b0, 3'b011, 32'h0, 32'h0);
    do_req(1'b0, 3'b111, 32'h4, 32'h0);
    do_req(1'b1, 3'b100, 32'h0, 32'h12345678);
    do_req(1'b1, 3'b011, 32'h8, 32'h12345678);
    check("illegal_no_acc", 64'(acc_addr_q.size()), 64'd0);

    for (int n = 0; n < 80; n++)
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'($urandom_range(0, 63)), $urandom);

    // MISALIGN_EN=0 instance: word-crossing LW errors with no access; aligned LW works
    @(negedge clk);
    nm_req_addr = 32'h2; nm_req_valid = 1'b1; t = cyc;
    @(posedge clk);
    #1 nm_req_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (nm_rsp_valid !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    check("nm_err_valid", 64'(nm_rsp_valid), 64'd1);
    check("nm_err_lat", 64'(cyc - t), 64'd1);
    check("nm_err_flag", 64'(nm_rsp_err), 64'd1);
    check("nm_err_rdata", 64'(nm_rsp_rdata), 64'd0);
    check("nm_err_no_acc", 64'(nm_en_cnt), 64'd0);
    @(negedge clk);
    nm_req_addr = 32'h4; nm_req_valid = 1'b1; t = cyc;
    @(posedge clk);
    #1 nm_req_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (nm_rsp_valid !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    check("nm_lw_lat", 64'(cyc - t), 64'd3);
    check("nm_lw_err", 64'(nm_rsp_err), 64'd0);
    check("nm_lw_data", 64'(nm_rsp_rdata), 64'h12345678);
    check("nm_lw_acc", 64'(nm_en_cnt), 64'd1);

    // Reset during ACC1 of a split store: abort, no response
    @(negedge clk);
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    ref_store(3'b010, 32'h16, 32'h55667788);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h16; req_wdata = 32'h55667788;
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!(mem_en === 1'b1 && mem_addr == 32'h18) && k < 10) begin @(negedge clk); k++; end
    check("rstmid_in_acc1", 64'(mem_en === 1'b1 && mem_addr == 32'h18), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_ready", 64'(req_ready), 64'd1);
    check("rstmid_mem_en", 64'(mem_en), 64'd0);
    check("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    do_req(1'b0, 3'b010, 32'h16, 32'h0);
    do_req(1'b0, 3'b010, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
